serial_adder_n: RTL and testbench
=================================

Name: serial_adder_n

Overview:
Bit-serial n-bit unsigned adder, the counterpart of the combinational subtractor_n. It processes one bit per clock, LSB first, using a 1-bit full adder and a carry flip-flop. Operation uses a start/busy/done handshake, and the result stays registered until the next operation completes. It is intended for area-constrained datapaths that share the arithmetic library with subtractor_n.

Parameters:
- nb_bit, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_n_i  input  1  reset, synchronous, active-low.
- start_i  input  1  request a new addition; sampled only in IDLE or DONE.
- a_i  input  nb_bit  operand A; captured on the accepting edge.
- b_i  input  nb_bit  operand B; captured on the accepting edge.
- busy_o  output  1  high while bits are being processed (RUN state).
- done_o  output  1  one-cycle pulse; sum_o and carry_o are valid from this cycle.
- sum_o  output  nb_bit  (a + b) mod 2^nb_bit; registered, held until the next completion.
- carry_o  output  1  carry out of bit nb_bit-1; registered, held with sum_o.

Behaviour:
- Reset: rst_n_i low at a rising edge forces state IDLE and clears all registers. After reset, busy_o=0, done_o=0, sum_o=0, carry_o=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 -> load shift_a<=a_i, shift_b<=b_i, carry<=0, bit_cnt<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Each cycle: full adder on (shift_a[0], shift_b[0], carry).
  - Sum bit shifts into the MSB of shift_s; shift_a and shift_b shift right; carry<=cout; bit_cnt++.
  - On the cycle with bit_cnt==nb_bit-1: sum_o<=final shift_s value (including the current bit), carry_o<=cout, go to DONE.
- DONE:
  - done_o=1 for exactly this one cycle.
  - start_i=1 -> reload operands and go to RUN (back-to-back operation, no IDLE cycle).
  - Otherwise go to IDLE.
- Latency: start_i accepted in cycle 0. busy_o is high in cycles 1..nb_bit. done_o is high in cycle nb_bit+1. Throughput is one result per nb_bit+1 cycles.
- start_i during RUN is ignored; operands are not re-sampled. a_i and b_i may change freely after the accepting edge.
- sum_o and carry_o change only on the transition into DONE; they keep the previous result for the whole of the next operation.
- Overflow wraps modulo 2^nb_bit; carry_o reports the overflow.
- nb_bit=1: RUN lasts one cycle; done_o is in cycle 2.
- Reset asserted mid-RUN: abort, go to IDLE with outputs cleared next cycle. No done_o pulse is produced.
- bit_cnt width is $clog2(nb_bit) with a minimum of 1.

Decomposition:
- Package arith_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} serial_state_t.
  - Constant default nb_bit.
- Sub-module full_adder_1b (a_i, b_i, cin_i, sum_o, cout_o), purely combinational. It mirrors the 1-bit cell of subtractor_n and is instantiated once.
- FSM, shift registers and result registers live in serial_adder_n.

Test Plan:
1. nb_bit=3, reset then start with a=3'b101, b=3'b011 -> busy_o high for cycles 1-3; done_o in cycle 4; sum_o=3'b000, carry_o=1.
2. nb_bit=8, a=8'h3C, b=8'h05 -> sum_o=8'h41, carry_o=0, done_o 9 cycles after start. Hold start_i low afterwards -> outputs remain 8'h41/0 and state returns to IDLE.
3. nb_bit=8, start held high continuously: a=8'hFF, b=8'h01 then a=8'h10, b=8'h20 -> first done gives 8'h00/carry 1. Second done comes 9 cycles later with 8'h30/0. sum_o holds 8'h00 during the second run.
4. nb_bit=8, pulse start_i again in cycle 4 of a run with different operands -> ignored; result equals the first operands' sum.
5. nb_bit=8, drive rst_n_i low in cycle 3 of a run -> next cycle busy_o=0, sum_o=0, carry_o=0; no done_o. A following start works normally.
6. nb_bit=1, all four operand pairs -> (0,0)->0/0, (1,0)->1/0, (0,1)->1/0, (1,1)->0/1, each with done_o in cycle 2.

Source files
------------

// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the small arithmetic library (serial_adder_n,
// subtractor_n and their common 1-bit cells).
//
// Contents:
//   serial_state_t  - state encoding of the bit-serial adder controller
//   NB_BIT_DEFAULT  - default operand width for the serial adder
//   cnt_width()     - width of a counter that must reach n-1 (minimum 1)
// ---------------------------------------------------------------------------
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_state_t;

  localparam int NB_BIT_DEFAULT = 8;

  // A width-1 operand still needs a 1-bit counter, so clamp the result.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/full_adder_1b.sv
// ---------------------------------------------------------------------------
// full_adder_1b
// Purely combinational 1-bit full adder; the same cell used by subtractor_n.
//
// Ports:
//   a_i    in   1  addend bit A
//   b_i    in   1  addend bit B
//   cin_i  in   1  carry in
//   sum_o  out  1  a_i ^ b_i ^ cin_i
//   cout_o out  1  carry out (majority of the three inputs)
// ---------------------------------------------------------------------------
module full_adder_1b (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  logic half_sum;

  assign half_sum = a_i ^ b_i;
  assign sum_o    = half_sum ^ cin_i;
  assign cout_o   = (a_i & b_i) | (cin_i & half_sum);

endmodule

// File: rtl/serial_adder_n.sv
// ---------------------------------------------------------------------------
// serial_adder_n
// Bit-serial unsigned adder. One operand bit pair is summed per clock, LSB
// first, through a single full_adder_1b and a carry flip-flop. A
// start/busy/done handshake frames each operation; the result registers keep
// the last completed sum until the next operation completes.
//
// Parameters:
//   nb_bit   operand / sum width, 1..32
//
// Ports:
//   clk_i    in   1       clock, rising edge
//   rst_n_i  in   1       synchronous active-low reset
//   start_i  in   1       request an addition (honoured in IDLE or DONE)
//   a_i      in   nb_bit  operand A, captured on the accepting edge
//   b_i      in   nb_bit  operand B, captured on the accepting edge
//   busy_o   out  1       high while bits are being processed
//   done_o   out  1       one-cycle pulse, result valid from this cycle
//   sum_o    out  nb_bit  (a + b) mod 2^nb_bit, held until next completion
//   carry_o  out  1       carry out of the MSB, held with sum_o
// ---------------------------------------------------------------------------
module serial_adder_n
  import arith_pkg::*;
#(
  parameter int nb_bit = NB_BIT_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [nb_bit-1:0] a_i,
  input  logic [nb_bit-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [nb_bit-1:0] sum_o,
  output logic              carry_o
);

  localparam int CNT_W = cnt_width(nb_bit);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(nb_bit - 1);

  serial_state_t state_reg, state_next;

  logic [nb_bit-1:0] shift_a_reg;
  logic [nb_bit-1:0] shift_b_reg;
  logic [nb_bit-1:0] shift_s_reg;
  logic [nb_bit-1:0] shift_s_next;
  logic              carry_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [nb_bit-1:0] sum_reg;
  logic              carry_out_reg;

  logic load;
  logic last_bit;
  logic fa_sum;
  logic fa_cout;

  // Single shared adder cell working on the current LSBs.
  full_adder_1b u_fa (
    .a_i    (shift_a_reg[0]),
    .b_i    (shift_b_reg[0]),
    .cin_i  (carry_reg),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  assign last_bit = (bit_cnt_reg == LAST_CNT);

  // Sum bits enter at the MSB; after nb_bit shifts the first (LSB) bit has
  // walked down to position 0, so the register then holds the sum in order.
  always_comb begin
    shift_s_next             = shift_s_reg >> 1;
    shift_s_next[nb_bit-1]   = fa_sum;
  end

  // Next-state logic and operand-load decision.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // A start here chains straight into the next run without IDLE.
        if (start_i) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath: operand shifters, carry, bit counter and result registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      shift_a_reg   <= '0;
      shift_b_reg   <= '0;
      shift_s_reg   <= '0;
      carry_reg     <= 1'b0;
      bit_cnt_reg   <= '0;
      sum_reg       <= '0;
      carry_out_reg <= 1'b0;
    end else if (load) begin
      shift_a_reg <= a_i;
      shift_b_reg <= b_i;
      shift_s_reg <= '0;
      carry_reg   <= 1'b0;
      bit_cnt_reg <= '0;
    end else if (state_reg == RUN) begin
      shift_a_reg <= shift_a_reg >> 1;
      shift_b_reg <= shift_b_reg >> 1;
      shift_s_reg <= shift_s_next;
      carry_reg   <= fa_cout;
      bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
      // Result registers only move on the way into DONE, so the previous
      // result stays visible for the whole of the following run.
      if (last_bit) begin
        sum_reg       <= shift_s_next;
        carry_out_reg <= fa_cout;
      end
    end
  end

  assign busy_o  = (state_reg == RUN);
  assign done_o  = (state_reg == DONE);
  assign sum_o   = sum_reg;
  assign carry_o = carry_out_reg;

endmodule

// File: tb/tb_serial_adder_n.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_n
// Directed bench for serial_adder_n at widths 3, 8 and 1. Cycle 0 is the
// cycle in which start is sampled; observations are taken 1 time unit after
// each rising edge, and inputs are driven at that same point.
// ---------------------------------------------------------------------------
module tb_serial_adder_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // nb_bit = 3 instance
  logic       rst3 = 1'b0, start3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0, sum3;
  logic       busy3, done3, carry3;

  // nb_bit = 8 instance
  logic       rst8 = 1'b0, start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       busy8, done8, carry8;

  // nb_bit = 1 instance
  logic       rst1 = 1'b0, start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic       busy1, done1, carry1;

  serial_adder_n #(.nb_bit(3)) d3 (
    .clk_i(clk), .rst_n_i(rst3), .start_i(start3), .a_i(a3), .b_i(b3),
    .busy_o(busy3), .done_o(done3), .sum_o(sum3), .carry_o(carry3));

  serial_adder_n #(.nb_bit(8)) d8 (
    .clk_i(clk), .rst_n_i(rst8), .start_i(start8), .a_i(a8), .b_i(b8),
    .busy_o(busy8), .done_o(done8), .sum_o(sum8), .carry_o(carry8));

  serial_adder_n #(.nb_bit(1)) d1 (
    .clk_i(clk), .rst_n_i(rst1), .start_i(start1), .a_i(a1), .b_i(b1),
    .busy_o(busy1), .done_o(done1), .sum_o(sum1), .carry_o(carry1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset all three instances and check the cleared output state.
  task automatic test_reset();
    rst3 = 1'b0; rst8 = 1'b0; rst1 = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({busy3, done3, sum3, carry3} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_n3 got busy=%b done=%b sum=%h carry=%b want all 0", busy3, done3, sum3, carry3);
    end
    n_cmp++;
    if ({busy8, done8, sum8, carry8} !== 11'b0) begin
      n_bad++;
      $display("FAIL reset_n8 got busy=%b done=%b sum=%h carry=%b want all 0", busy8, done8, sum8, carry8);
    end
    n_cmp++;
    if ({busy1, done1, sum1, carry1} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_n1 got busy=%b done=%b sum=%h carry=%b want all 0", busy1, done1, sum1, carry1);
    end
    rst3 = 1'b1; rst8 = 1'b1; rst1 = 1'b1;
    tick();
    $display("reset: all instances cleared");
  endtask

  // 5 + 3 = 8 -> wraps to 0 with carry in a 3-bit adder.
  task automatic test_n3_basic();
    start3 = 1'b1; a3 = 3'b101; b3 = 3'b011;
    tick();
    start3 = 1'b0; a3 = 3'b000; b3 = 3'b000;
    for (int c = 1; c <= 4; c++) begin
      n_cmp++;
      if (busy3 !== (c <= 3) || done3 !== (c == 4)) begin
        n_bad++;
        $display("FAIL n3_timing cycle %0d got busy=%b done=%b want busy=%b done=%b", c, busy3, done3, c <= 3, c == 4);
      end
      if (c == 4) begin
        n_cmp++;
        if (sum3 !== 3'b000 || carry3 !== 1'b1) begin
          n_bad++;
          $display("FAIL n3_result got sum=%b carry=%b want sum=000 carry=1", sum3, carry3);
        end
        $display("n3: 101+011 -> sum=%b carry=%b", sum3, carry3);
      end
      tick();
    end
  endtask

  // 0x3C + 0x05 = 0x41, then idle with results held.
  task automatic test_n8_basic_hold();
    start8 = 1'b1; a8 = 8'h3C; b8 = 8'h05;
    tick();
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    for (int c = 1; c <= 9; c++) begin
      n_cmp++;
      if (busy8 !== (c <= 8) || done8 !== (c == 9)) begin
        n_bad++;
        $display("FAIL n8_timing cycle %0d got busy=%b done=%b want busy=%b done=%b", c, busy8, done8, c <= 8, c == 9);
      end
      if (c == 9) begin
        n_cmp++;
        if (sum8 !== 8'h41 || carry8 !== 1'b0) begin
          n_bad++;
          $display("FAIL n8_result got sum=%h carry=%b want sum=41 carry=0", sum8, carry8);
        end
        $display("n8: 3c+05 -> sum=%h carry=%b", sum8, carry8);
      end
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h41 || carry8 !== 1'b0) begin
        n_bad++;
        $display("FAIL n8_hold got busy=%b done=%b sum=%h carry=%b want 0/0/41/0", busy8, done8, sum8, carry8);
      end
      tick();
    end
  endtask

  // Start held high: FF+01 chains directly into 10+20.
  task automatic test_back_to_back();
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'h01;
    tick();
    a8 = 8'h10; b8 = 8'h20;
    for (int c = 1; c <= 18; c++) begin
      n_cmp++;
      if (busy8 !== (c != 9 && c != 18) || done8 !== (c == 9 || c == 18)) begin
        n_bad++;
        $display("FAIL b2b_timing cycle %0d got busy=%b done=%b want busy=%b done=%b", c, busy8, done8, c != 9 && c != 18, c == 9 || c == 18);
      end
      if (c == 9) begin
        n_cmp++;
        if (sum8 !== 8'h00 || carry8 !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_first got sum=%h carry=%b want sum=00 carry=1", sum8, carry8);
        end
        $display("b2b: ff+01 -> sum=%h carry=%b", sum8, carry8);
      end
      if (c > 9 && c < 18) begin
        n_cmp++;
        if (sum8 !== 8'h00 || carry8 !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_hold cycle %0d got sum=%h carry=%b want sum=00 carry=1", c, sum8, carry8);
        end
      end
      if (c == 18) begin
        n_cmp++;
        if (sum8 !== 8'h30 || carry8 !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_second got sum=%h carry=%b want sum=30 carry=0", sum8, carry8);
        end
        $display("b2b: 10+20 -> sum=%h carry=%b", sum8, carry8);
        start8 = 1'b0;
      end
      tick();
    end
    n_cmp++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_idle got busy=%b done=%b want 0/0", busy8, done8);
    end
  endtask

  // A start pulse mid-run with other operands must be ignored.
  task automatic test_start_ignored();
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
    tick();
    start8 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 4) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end else begin
        start8 = 1'b0;
      end
      if (c == 9) begin
        n_cmp++;
        if (done8 !== 1'b1 || sum8 !== 8'h46 || carry8 !== 1'b0) begin
          n_bad++;
          $display("FAIL ignore_start got done=%b sum=%h carry=%b want done=1 sum=46 carry=0", done8, sum8, carry8);
        end
        $display("ignore: 12+34 (ff+ff pulsed mid-run) -> sum=%h carry=%b", sum8, carry8);
      end
      tick();
    end
    n_cmp++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_idle got busy=%b done=%b want 0/0", busy8, done8);
    end
  endtask

  // Reset in cycle 3 aborts the run; a later start completes normally.
  task automatic test_reset_mid_run();
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    rst8 = 1'b0;
    tick();
    rst8 = 1'b1;
    n_cmp++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || carry8 !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_clear got busy=%b done=%b sum=%h carry=%b want 0/0/00/0", busy8, done8, sum8, carry8);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_no_done cycle %0d got busy=%b done=%b want 0/0", c, busy8, done8);
      end
    end
    $display("abort: run aborted by reset, outputs cleared");
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    tick();
    start8 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 9) begin
        n_cmp++;
        if (done8 !== 1'b1 || sum8 !== 8'hFF || carry8 !== 1'b0) begin
          n_bad++;
          $display("FAIL abort_restart got done=%b sum=%h carry=%b want done=1 sum=ff carry=0", done8, sum8, carry8);
        end
        $display("abort: restart aa+55 -> sum=%h carry=%b", sum8, carry8);
      end
      tick();
    end
  endtask

  // Width-1 adder: all four operand pairs.
  task automatic test_n1_all();
    logic [1:0] exp_tab [4];
    exp_tab[0] = 2'b00; exp_tab[1] = 2'b01; exp_tab[2] = 2'b01; exp_tab[3] = 2'b10;
    for (int p = 0; p < 4; p++) begin
      start1 = 1'b1; a1 = 1'(p & 1); b1 = 1'((p >> 1) & 1);
      tick();
      start1 = 1'b0;
      n_cmp++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        n_bad++;
        $display("FAIL n1_cycle1 pair %0d got busy=%b done=%b want 1/0", p, busy1, done1);
      end
      tick();
      n_cmp++;
      if (busy1 !== 1'b0 || done1 !== 1'b1 || {carry1, sum1} !== exp_tab[p]) begin
        n_bad++;
        $display("FAIL n1_result pair %0d got busy=%b done=%b carry=%b sum=%b want 0/1 carry=%b sum=%b",
                 p, busy1, done1, carry1, sum1, exp_tab[p][1], exp_tab[p][0]);
      end
      $display("n1: %0d+%0d -> sum=%b carry=%b", p & 1, (p >> 1) & 1, sum1, carry1);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_n3_basic();
    test_n8_basic_hold();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_run();
    test_n1_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
